op_result_arbiter: RTL and testbench
====================================

# op_result_arbiter

Single-driver resolution stage for the bitwise-operation datapath. Up to three requesters compete for one output: NOT of A, XOR of A and B, and AND of A and B. The block grants one requester per cycle and computes that operation on the operands sampled in the grant cycle. It then holds the result in a single output register behind a valid/ready handshake, so `y_out` always has exactly one sequential driver.

## Interface
Parameters:
- `W`, default 8: operand and result width in bits.

Ports:
- `clk_in`, input, 1: the only clock; all state updates on its rising edge.
- `rst_in`, input, 1: asynchronous, active-high reset.
- `a_in`, input, W: operand A.
- `b_in`, input, W: operand B.
- `req_in`, input, 3: operation requests. Bit 0 is NOT A, bit 1 is A XOR B, bit 2 is A AND B. Level-sensitive; each bit is held until its grant.
- `gnt_out`, output, 3: one-hot grant, combinational, high only in the accept cycle.
- `y_out`, output, W: registered result.
- `y_op_out`, output, 2: operation that produced `y_out`. 0 is NOT, 1 is XOR, 2 is AND; 3 is never produced.
- `y_valid_out`, output, 1: `y_out` and `y_op_out` are valid.
- `y_ready_in`, input, 1: downstream accepts the result.

## Operation
- Reset values:
  - `y_out` = 0, `y_op_out` = 0, `y_valid_out` = 0.
  - `gnt_out` = 0 while `rst_in` is high.
  - Round-robin pointer `last` = 2.
- Output slot is free when `y_valid_out` = 0, or when `y_valid_out` = 1 and `y_ready_in` = 1 (slot drains and refills in the same cycle).
- Accept condition: slot free and `req_in` != 0. Otherwise `gnt_out` = 0 and the block holds its state.
- On accept:
  - Exactly one `gnt_out` bit is high, selected by the arbitration rule below.
  - At the clock edge: `y_out` ← op(`a_in`, `b_in`) using the operands present in that cycle; `y_op_out` ← granted index; `y_valid_out` ← 1; `last` ← granted index.
- On a handshake (`y_valid_out` & `y_ready_in`) with no accept: `y_valid_out` ← 0. `y_out` and `y_op_out` keep their last values.
- Backpressure: while `y_valid_out` = 1 and `y_ready_in` = 0:
  - `y_out`, `y_op_out` and `y_valid_out` are held stable.
  - No grant is issued.
  - Changes on `a_in`/`b_in` have no effect.
- Requesters deassert their `req_in` bit in the cycle after their grant. A bit still high after its grant is treated as a new request.
- Operations are bitwise on W bits. There is no carry and no width change.
- Reset mid-operation: a pending result is discarded and `y_valid_out` drops immediately (asynchronous). No grant is issued until after reset deasserts.

## Timing
- Latency: grant in cycle N; result valid at the output from cycle N+1.
- Throughput: one result per cycle while `y_ready_in` = 1 and requests are pending.
- `gnt_out` is a combinational function of `req_in`, `y_valid_out`, `y_ready_in` and `last`. It has no path from `a_in` or `b_in`.
- Simultaneous drain and accept in one cycle: the old result is consumed and the new result appears at the next edge. `y_valid_out` stays 1 with no bubble.

## Configuration
- `ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The search starts at index (`last`+1) mod 3 and wraps through 0, 1, 2. The first set request bit found is granted.
  - After reset the first search starts at index 0.
- `ROUND_ROBIN_EN` undefined: fixed priority.
  - Bit 0 wins over bit 1, and bit 1 wins over bit 2.
  - The `last` register is not built.
  - Continuous low-index requests may starve higher indices; this is accepted by design.

## Test plan
- Reset and single request. Release reset. W=8, `a_in`=0xA5, `b_in`=0x0F, `req_in`=3'b010, `y_ready_in`=1.
  - Required: `gnt_out`=3'b010 in the same cycle.
  - Next cycle: `y_out`=0xAA, `y_op_out`=1, `y_valid_out`=1.
- All three requests held high, `y_ready_in`=1, `a_in`=0xF0, `b_in`=0x3C.
  - With `ROUND_ROBIN_EN`: grants 001, 010, 100, 001 on consecutive cycles; results 0x0F, 0xCC, 0x30.
  - Without `ROUND_ROBIN_EN`: `gnt_out`=001 every cycle.
- Backpressure. Hold a valid result with `y_ready_in`=0 for 4 cycles while `a_in` changes and `req_in`=3'b100.
  - Required: `y_out` unchanged and `gnt_out`=0 for all 4 cycles.
  - Then raise `y_ready_in`: grant issued that cycle, new AND result valid next cycle with no bubble.
- Drain without refill. Set `req_in`=0 and `y_ready_in`=1 with a result valid.
  - Required: `y_valid_out` falls to 0 next cycle; `y_out` holds its value.
- Reset mid-operation. Assert `rst_in` asynchronously between edges while `y_valid_out`=1.
  - Required: `y_valid_out`, `y_out` and `y_op_out` are 0 immediately; `gnt_out`=0 throughout reset.
  - First grant after reset is index 0 when `req_in`=3'b111.

Source files
------------

// File: rtl/op_result_arbiter_if.sv
// Operand, request/grant and result handshake bundle for op_result_arbiter.
interface op_result_arbiter_if #(
  parameter int W = 8
);
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [2:0]   req_in;
  logic [2:0]   gnt_out;
  logic [W-1:0] y_out;
  logic [1:0]   y_op_out;
  logic         y_valid_out;
  logic         y_ready_in;

  modport slave (
    input  a_in, b_in, req_in, y_ready_in,
    output gnt_out, y_out, y_op_out, y_valid_out
  );

  modport master (
    output a_in, b_in, req_in, y_ready_in,
    input  gnt_out, y_out, y_op_out, y_valid_out
  );
endinterface

// File: rtl/op_result_arbiter.sv
// Grants one of NOT/XOR/AND per cycle into a single valid/ready result register.
// Define ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (bit 0 highest).
module op_result_arbiter #(
  parameter int W = 8
) (
  input logic             clk_in,
  input logic             rst_in,
  op_result_arbiter_if.slave bus
);

  logic [W-1:0] y_q, y_d;
  logic [1:0]   op_q, op_d;
  logic         valid_q, valid_d;
  logic [1:0]   gidx_s;
  logic         accept_s;
  logic [2:0]   gnt_s;

  function automatic logic [W-1:0] op_eval(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      2'd0:    r = ~a;
      2'd1:    r = a ^ b;
      2'd2:    r = a & b;
      default: r = {W{1'b0}};
    endcase
    return r;
  endfunction

`ifdef ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;

  // Search begins just after the last granted index and wraps.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] pick;
    case (last)
      2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
    return pick;
  endfunction

  assign gidx_s = rr_pick(bus.req_in, last_q);
`else
  assign gidx_s = bus.req_in[0] ? 2'd0 : (bus.req_in[1] ? 2'd1 : 2'd2);
`endif

  assign accept_s = !rst_in && (!valid_q || bus.y_ready_in) && (bus.req_in != 3'b000);
  assign gnt_s    = accept_s ? (3'b001 << gidx_s) : 3'b000;

  always_comb begin
    y_d     = y_q;
    op_d    = op_q;
    valid_d = valid_q;
`ifdef ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    if (accept_s) begin
      y_d     = op_eval(gidx_s, bus.a_in, bus.b_in);
      op_d    = gidx_s;
      valid_d = 1'b1;
`ifdef ROUND_ROBIN_EN
      last_d  = gidx_s;
`endif
    end else if (valid_q && bus.y_ready_in) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      y_q     <= {W{1'b0}};
      op_q    <= 2'd0;
      valid_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_q  <= 2'd2;
`endif
    end else begin
      y_q     <= y_d;
      op_q    <= op_d;
      valid_q <= valid_d;
`ifdef ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.gnt_out     = gnt_s;
  assign bus.y_out       = y_q;
  assign bus.y_op_out    = op_q;
  assign bus.y_valid_out = valid_q;

endmodule

// File: tb/tb_op_result_arbiter.sv
// Directed bench for op_result_arbiter with a per-cycle reference model and literal checkpoints.
module tb_op_result_arbiter;

`ifdef ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  op_result_arbiter_if #(.W(8)) bus ();

  op_result_arbiter #(.W(8)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: the result slot and the index of the most recent grant.
  logic       m_valid, n_valid;
  logic [7:0] m_y, n_y;
  logic [1:0] m_op, n_op;
  int         m_last, n_last;

  function automatic int pick(input logic [2:0] req, input int last);
    int start;
    start = RR_MODE ? (last + 1) % 3 : 0;
    for (int k = 0; k < 3; k++) begin
      if (req[(start + k) % 3]) return (start + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [7:0] apply_op(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0:       return ~a;
      1:       return a ^ b;
      default: return a & b;
    endcase
  endfunction

  always @(negedge clk) begin
    int         idx;
    logic [2:0] eg;
    eg = 3'b000;
    n_valid = m_valid; n_y = m_y; n_op = m_op; n_last = m_last;
    if (rst) begin
      n_valid = 1'b0; n_y = 8'h00; n_op = 2'd0; n_last = 2;
    end else if ((!m_valid || bus.y_ready_in) && bus.req_in != 3'b000) begin
      idx     = pick(bus.req_in, m_last);
      eg      = 3'b001 << idx;
      n_valid = 1'b1;
      n_y     = apply_op(idx, bus.a_in, bus.b_in);
      n_op    = 2'(idx);
      n_last  = idx;
    end else if (m_valid && bus.y_ready_in) begin
      n_valid = 1'b0;
    end
    chk("model_gnt",   {29'd0, bus.gnt_out},    {29'd0, eg});
    chk("model_valid", {31'd0, bus.y_valid_out}, {31'd0, m_valid});
    chk("model_y",     {24'd0, bus.y_out},       {24'd0, m_y});
    chk("model_op",    {30'd0, bus.y_op_out},    {30'd0, m_op});
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_y <= 8'h00; m_op <= 2'd0; m_last <= 2;
    end else begin
      m_valid <= n_valid; m_y <= n_y; m_op <= n_op; m_last <= n_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] exp_g [4];
  logic [7:0] exp_y [3];
  logic [1:0] exp_o [3];

  initial begin
`ifdef ROUND_ROBIN_EN
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    exp_y[0] = 8'h0F;  exp_y[1] = 8'hCC;  exp_y[2] = 8'h30;
    exp_o[0] = 2'd0;   exp_o[1] = 2'd1;   exp_o[2] = 2'd2;
`else
    exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001; exp_g[3] = 3'b001;
    exp_y[0] = 8'h0F;  exp_y[1] = 8'h0F;  exp_y[2] = 8'h0F;
    exp_o[0] = 2'd0;   exp_o[1] = 2'd0;   exp_o[2] = 2'd0;
`endif
    bus.a_in = 8'h00; bus.b_in = 8'h00; bus.req_in = 3'b111; bus.y_ready_in = 1'b0;
    tick(); tick();
    #1;
    chk("rst_gnt",   {29'd0, bus.gnt_out},     32'd0);
    chk("rst_valid", {31'd0, bus.y_valid_out}, 32'd0);
    chk("rst_y",     {24'd0, bus.y_out},       32'd0);
    chk("rst_op",    {30'd0, bus.y_op_out},    32'd0);

    // Single XOR request.
    tick();
    rst = 1'b0; bus.a_in = 8'hA5; bus.b_in = 8'h0F; bus.req_in = 3'b010; bus.y_ready_in = 1'b1;
    #1 chk("single_gnt", {29'd0, bus.gnt_out}, 32'h2);
    tick();
    bus.req_in = 3'b000;
    #1;
    chk("single_y",     {24'd0, bus.y_out},       32'hAA);
    chk("single_op",    {30'd0, bus.y_op_out},    32'd1);
    chk("single_valid", {31'd0, bus.y_valid_out}, 32'd1);
    // Drain without refill.
    tick();
    #1;
    chk("drain_valid", {31'd0, bus.y_valid_out}, 32'd0);
    chk("drain_y",     {24'd0, bus.y_out},       32'hAA);

    // All three requests held, starting from a fresh pointer.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    bus.a_in = 8'hF0; bus.b_in = 8'h3C; bus.req_in = 3'b111; bus.y_ready_in = 1'b1;
    #1 chk("all3_gnt0", {29'd0, bus.gnt_out}, {29'd0, exp_g[0]});
    for (int k = 1; k < 4; k++) begin
      tick();
      #1;
      chk("all3_y",   {24'd0, bus.y_out},    {24'd0, exp_y[k-1]});
      chk("all3_op",  {30'd0, bus.y_op_out}, {30'd0, exp_o[k-1]});
      chk("all3_gnt", {29'd0, bus.gnt_out},  {29'd0, exp_g[k]});
    end

    // Backpressure with operands moving underneath.
    tick();
    bus.y_ready_in = 1'b0; bus.req_in = 3'b100;
    for (int k = 0; k < 4; k++) begin
      bus.a_in = 8'h11 + 8'(k * 16);
      #1;
      chk("bp_gnt",   {29'd0, bus.gnt_out},     32'd0);
      chk("bp_y",     {24'd0, bus.y_out},       32'h0F);
      chk("bp_valid", {31'd0, bus.y_valid_out}, 32'd1);
      tick();
    end
    bus.y_ready_in = 1'b1; bus.a_in = 8'hCC; bus.b_in = 8'hAA;
    #1 chk("bp_release_gnt", {29'd0, bus.gnt_out}, 32'h4);
    tick();
    bus.req_in = 3'b000;
    #1;
    chk("bp_and_y",     {24'd0, bus.y_out},       32'h88);
    chk("bp_and_op",    {30'd0, bus.y_op_out},    32'd2);
    chk("bp_and_valid", {31'd0, bus.y_valid_out}, 32'd1);

    // Asynchronous reset while a result is pending.
    #1 rst = 1'b1;
    bus.req_in = 3'b111;
    #1;
    chk("arst_valid", {31'd0, bus.y_valid_out}, 32'd0);
    chk("arst_y",     {24'd0, bus.y_out},       32'd0);
    chk("arst_op",    {30'd0, bus.y_op_out},    32'd0);
    chk("arst_gnt",   {29'd0, bus.gnt_out},     32'd0);
    tick();
    chk("arst_gnt_hold", {29'd0, bus.gnt_out}, 32'd0);
    tick();
    rst = 1'b0; bus.a_in = 8'h5A;
    #1 chk("post_rst_gnt", {29'd0, bus.gnt_out}, 32'h1);
    tick();
    bus.req_in = 3'b000;
    #1 chk("post_rst_y", {24'd0, bus.y_out}, 32'hA5);

    // Mixed request/ready patterns checked by the model alone.
    for (int i = 0; i < 48; i++) begin
      tick();
      bus.req_in     = 3'((i * 5 + 3) % 8);
      bus.y_ready_in = ((i % 3) != 1);
      bus.a_in       = 8'(i * 37 + 11);
      bus.b_in       = 8'(i * 91 + 7);
    end
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
